tpx3_rx_aligner: RTL and testbench

//  Serial-to-parallel comma aligner for one Timepix3 8b/10b data lane. Sits

---
 rtl/tpx3_rx_aligner.sv | 197 +++++++++++++++++++
 tb/tb_tpx3_rx_aligner.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tpx3_rx_aligner.sv
// ---------------------------------------------------------------------------
// tpx3_rx_aligner
//   Comma aligner for one Timepix3 8b/10b serial data lane. It sits between
//   the lane pin (sampled one bit per i_clk320 rising edge) and the 8b/10b
//   decoder. It finds K28.5 commas, locks the 10-bit symbol boundary, and
//   emits one aligned symbol every 10 clocks. It also tracks loss of lock.
//
//   Lock acquisition: SEARCH -> CHECK -> LOCKED after LOCK_COMMAS commas
//   that land on the same boundary. The first comma counts toward that
//   total. Lock drops after LOSS_COMMAS consecutive commas seen off the
//   locked boundary.
//
// Ports
//   i_clk320      in   1   bit clock, one line bit per rising edge
//   i_rst_n       in   1   asynchronous active-low reset
//   i_enable      in   1   0: FSM held in SEARCH, counters cleared, no output
//   i_rx_bit      in   1   serial line bit, 8b/10b bit 'a' transmitted first
//   o_data_out    out  10  aligned symbol, bit0='a' ... bit9='j'
//   o_data_valid  out  1   one-cycle strobe, o_data_out valid
//   o_data_k      out  1   o_data_out is K28.5 (either disparity)
//   o_locked      out  1   FSM is in LOCKED
//   o_loss_cnt    out  8   lock-loss events, saturates at 255
// ---------------------------------------------------------------------------
module tpx3_rx_aligner #(
  parameter int LOCK_COMMAS = 4,
  parameter int LOSS_COMMAS = 3
) (
  input  logic       i_clk320,
  input  logic       i_rst_n,
  input  logic       i_enable,
  input  logic       i_rx_bit,
  output logic [9:0] o_data_out,
  output logic       o_data_valid,
  output logic       o_data_k,
  output logic       o_locked,
  output logic [7:0] o_loss_cnt
);

  localparam int GW = $clog2(LOCK_COMMAS + 1);
  localparam int MW = $clog2(LOSS_COMMAS + 1);

  // K28.5 as it sits in the shift register (bit0 = 'a'), both disparities.
  localparam logic [9:0] K285_RDN = 10'b0101111100;
  localparam logic [9:0] K285_RDP = 10'b1010000011;

  localparam logic [GW-1:0] GOOD_ONE  = GW'(1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_COMMAS - 1);
  localparam logic [MW-1:0] MISS_ONE  = MW'(1);
  localparam logic [MW-1:0] MISS_LAST = MW'(LOSS_COMMAS - 1);
  localparam logic [3:0]    PHASE_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Full-symbol K28.5 match, independent of running disparity.
  function automatic logic is_comma(input logic [9:0] sym);
    return (sym == K285_RDN) || (sym == K285_RDP);
  endfunction

  logic [9:0]    r_sr;
  logic [3:0]    r_bit_cnt;
  logic [GW-1:0] r_good_cnt;
  logic [MW-1:0] r_miss_cnt;
  state_t        r_state;

  logic          w_comma;
  logic          w_aligned;
  logic          w_realign;

  // Comma/phase decode on the current shift-register contents.
  always_comb begin
    w_comma   = is_comma(r_sr);
    w_aligned = (r_bit_cnt == PHASE_MAX);
    w_realign = 1'b0;
    if (i_enable && w_comma) begin
      case (r_state)
        ST_SEARCH: w_realign = 1'b1;
        ST_CHECK:  w_realign = !w_aligned;
        default:   w_realign = 1'b0;  // LOCKED never moves the boundary
      endcase
    end else begin
      w_realign = 1'b0;
    end
  end

  // Line shift register: newest bit enters at bit9, oldest leaves bit0.
  always_ff @(posedge i_clk320 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sr <= 10'd0;
    end else begin
      r_sr <= {i_rx_bit, r_sr[9:1]};
    end
  end

  // Mod-10 symbol phase. A realign zeroes it so that the next boundary is
  // exactly ten edges after the comma that caused it.
  always_ff @(posedge i_clk320 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bit_cnt <= 4'd0;
    end else if (w_realign) begin
      r_bit_cnt <= 4'd0;
    end else if (r_bit_cnt == PHASE_MAX) begin
      r_bit_cnt <= 4'd0;
    end else begin
      r_bit_cnt <= r_bit_cnt + 4'd1;
    end
  end

  // Alignment FSM together with its registered outputs.
  always_ff @(posedge i_clk320 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_SEARCH;
      r_good_cnt   <= '0;
      r_miss_cnt   <= '0;
      o_data_out   <= 10'd0;
      o_data_valid <= 1'b0;
      o_data_k     <= 1'b0;
      o_locked     <= 1'b0;
      o_loss_cnt   <= 8'd0;
    end else if (!i_enable) begin
      // Loss counter is neither bumped nor cleared while disabled.
      r_state      <= ST_SEARCH;
      r_good_cnt   <= '0;
      r_miss_cnt   <= '0;
      o_data_valid <= 1'b0;
      o_locked     <= 1'b0;
    end else begin
      // Emission depends on the state before this edge, so the symbol that
      // completes lock is not emitted.
      if ((r_state == ST_LOCKED) && w_aligned) begin
        o_data_out   <= r_sr;
        o_data_k     <= w_comma;
        o_data_valid <= 1'b1;
      end else begin
        o_data_valid <= 1'b0;
      end

      case (r_state)
        ST_SEARCH: begin
          if (w_comma) begin
            r_good_cnt <= GOOD_ONE;
            if (LOCK_COMMAS <= 1) begin
              r_state    <= ST_LOCKED;
              r_miss_cnt <= '0;
              o_locked   <= 1'b1;
            end else begin
              r_state <= ST_CHECK;
            end
          end
        end

        ST_CHECK: begin
          if (w_comma && w_aligned) begin
            r_good_cnt <= r_good_cnt + GOOD_ONE;
            if (r_good_cnt == GOOD_LAST) begin
              r_state    <= ST_LOCKED;
              r_miss_cnt <= '0;
              o_locked   <= 1'b1;
            end
          end else if (w_comma) begin
            // Boundary moved: restart the count on the new phase.
            r_good_cnt <= GOOD_ONE;
          end
        end

        ST_LOCKED: begin
          if (w_comma && w_aligned) begin
            r_miss_cnt <= '0;
          end else if (w_comma) begin
            if (r_miss_cnt == MISS_LAST) begin
              r_state    <= ST_SEARCH;
              r_good_cnt <= '0;
              r_miss_cnt <= '0;
              o_locked   <= 1'b0;
              if (o_loss_cnt != 8'hFF) begin
                o_loss_cnt <= o_loss_cnt + 8'd1;
              end
            end else begin
              r_miss_cnt <= r_miss_cnt + MISS_ONE;
            end
          end
        end

        default: begin
          r_state    <= ST_SEARCH;
          r_good_cnt <= '0;
          r_miss_cnt <= '0;
          o_locked   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tpx3_rx_aligner.sv
// ---------------------------------------------------------------------------
// tb_tpx3_rx_aligner
//   Directed bench for tpx3_rx_aligner. The serial stream is driven 1 ns
//   after each rising edge. Outputs are observed at the same point, after
//   the edge has settled. Expected timings are counted in whole symbols
//   relative to the first comma sent.
// ---------------------------------------------------------------------------
module tb_tpx3_rx_aligner;

  localparam logic [9:0] KA = 10'h17C;  // K28.5, RD- form in register order
  localparam logic [9:0] KB = 10'h283;  // K28.5, RD+ form
  localparam logic [9:0] D1 = 10'h352;
  localparam logic [9:0] D2 = 10'h351;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       rx_bit;
  logic [9:0] data_out;
  logic       data_valid;
  logic       data_k;
  logic       locked;
  logic [7:0] loss_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // Per-symbol observations gathered by send_sym.
  logic       v_first;
  logic [9:0] d_first;
  logic       k_first;
  logic       l_first;
  logic       l_last;
  int         vcnt;
  int         vsum;

  always #5 clk = ~clk;

  tpx3_rx_aligner #(.LOCK_COMMAS(4), .LOSS_COMMAS(3)) dut (
    .i_clk320    (clk),
    .i_rst_n     (rst_n),
    .i_enable    (enable),
    .i_rx_bit    (rx_bit),
    .o_data_out  (data_out),
    .o_data_valid(data_valid),
    .o_data_k    (data_k),
    .o_locked    (locked),
    .o_loss_cnt  (loss_cnt)
  );

  task automatic tick(input logic b);
    rx_bit = b;
    @(posedge clk);
    #1;
    if (data_valid) vsum++;
  endtask

  // Send one symbol, 'a' first, and record what the outputs showed after
  // its first bit and after its last bit.
  task automatic send_sym(input logic [9:0] sym);
    int v0;
    v0 = vsum;
    for (int i = 0; i < 10; i++) begin
      tick(sym[i]);
      if (i == 0) begin
        v_first = data_valid;
        d_first = data_out;
        k_first = data_k;
        l_first = locked;
      end
    end
    vcnt   = vsum - v0;
    l_last = locked;
  endtask

  // Fresh acquisition from SEARCH: four commas, lock on the first bit of the
  // fifth symbol, and the first emitted symbol is the fifth comma.
  task automatic relock_fresh(input string tag);
    vsum = 0;
    send_sym(KA); send_sym(KB); send_sym(KA); send_sym(KB);
    n_checks++;
    if (l_last !== 1'b0) $display("FAIL %s_early_lock: locked=%b expected 0", tag, l_last);
    else n_pass++;
    n_checks++;
    if (vsum !== 0) $display("FAIL %s_early_valid: valids=%0d expected 0", tag, vsum);
    else n_pass++;
    send_sym(KA);
    n_checks++;
    if (l_first !== 1'b1 || vcnt !== 0)
      $display("FAIL %s_lock_edge: locked=%b valids=%0d expected 1 and 0", tag, l_first, vcnt);
    else n_pass++;
    send_sym(KB);
    n_checks++;
    if (v_first !== 1'b1 || d_first !== KA || k_first !== 1'b1)
      $display("FAIL %s_first_out: valid=%b data=%h k=%b expected 1 %h 1", tag, v_first, d_first, k_first, KA);
    else n_pass++;
  endtask

  task automatic test_reset;
    rst_n  = 1'b0;
    enable = 1'b0;
    rx_bit = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (data_out !== 10'd0) $display("FAIL reset_data: got %h expected 000", data_out);
    else n_pass++;
    n_checks++;
    if (data_valid !== 1'b0 || data_k !== 1'b0)
      $display("FAIL reset_valid_k: got %b%b expected 00", data_valid, data_k);
    else n_pass++;
    n_checks++;
    if (locked !== 1'b0) $display("FAIL reset_locked: got %b expected 0", locked);
    else n_pass++;
    n_checks++;
    if (loss_cnt !== 8'd0) $display("FAIL reset_loss: got %0d expected 0", loss_cnt);
    else n_pass++;
    rst_n  = 1'b1;
    enable = 1'b1;
  endtask

  task automatic test_lock_stream;
    vsum = 0;
    send_sym(KA); send_sym(KB); send_sym(KA); send_sym(KB);
    n_checks++;
    if (l_last !== 1'b0 || vsum !== 0)
      $display("FAIL s1_prelock: locked=%b valids=%0d expected 0 0", l_last, vsum);
    else n_pass++;
    send_sym(KA);
    n_checks++;
    if (l_first !== 1'b1) $display("FAIL s1_lock_time: locked=%b expected 1", l_first);
    else n_pass++;
    n_checks++;
    if (vcnt !== 0) $display("FAIL s1_lock_sym_emitted: valids=%0d expected 0", vcnt);
    else n_pass++;
    send_sym(KB);
    n_checks++;
    if (v_first !== 1'b1 || d_first !== KA || k_first !== 1'b1 || vcnt !== 1)
      $display("FAIL s1_out0: valid=%b data=%h k=%b n=%0d expected 1 %h 1 1", v_first, d_first, k_first, vcnt, KA);
    else n_pass++;
    send_sym(D1);
    n_checks++;
    if (d_first !== KB || k_first !== 1'b1 || vcnt !== 1)
      $display("FAIL s1_out1: data=%h k=%b n=%0d expected %h 1 1", d_first, k_first, vcnt, KB);
    else n_pass++;
    send_sym(D2);
    n_checks++;
    if (v_first !== 1'b1 || d_first !== D1 || k_first !== 1'b0)
      $display("FAIL s1_out2: valid=%b data=%h k=%b expected 1 %h 0", v_first, d_first, k_first, D1);
    else n_pass++;
    send_sym(D1);
    n_checks++;
    if (d_first !== D2 || k_first !== 1'b0 || vcnt !== 1)
      $display("FAIL s1_out3: data=%h k=%b n=%0d expected %h 0 1", d_first, k_first, vcnt, D2);
    else n_pass++;
  endtask

  task automatic test_misaligned_loss;
    tick(1'b0);  // one extra bit shifts every following comma by one phase
    send_sym(KA); send_sym(KB); send_sym(KA);
    n_checks++;
    if (l_last !== 1'b1 || loss_cnt !== 8'd0)
      $display("FAIL s2_two_misses: locked=%b loss=%0d expected 1 0", l_last, loss_cnt);
    else n_pass++;
    send_sym(KB);
    n_checks++;
    if (l_first !== 1'b0) $display("FAIL s2_drop: locked=%b expected 0", l_first);
    else n_pass++;
    n_checks++;
    if (loss_cnt !== 8'd1) $display("FAIL s2_loss_cnt: got %0d expected 1", loss_cnt);
    else n_pass++;
    send_sym(KA); send_sym(KB); send_sym(KA);
    n_checks++;
    if (l_last !== 1'b0) $display("FAIL s2_relock_early: locked=%b expected 0", l_last);
    else n_pass++;
    send_sym(KB);
    n_checks++;
    if (l_first !== 1'b1 || vcnt !== 0)
      $display("FAIL s2_relock: locked=%b valids=%0d expected 1 0", l_first, vcnt);
    else n_pass++;
    send_sym(KA);
    n_checks++;
    if (v_first !== 1'b1 || d_first !== KB)
      $display("FAIL s2_new_phase_out: valid=%b data=%h expected 1 %h", v_first, d_first, KB);
    else n_pass++;
  endtask

  task automatic test_check_slip;
    enable = 1'b0;
    repeat (10) tick(1'b0);
    enable = 1'b1;
    vsum = 0;
    send_sym(KA); send_sym(KB);
    repeat (3) tick(1'b0);
    send_sym(KA); send_sym(KB); send_sym(KA);
    n_checks++;
    if (l_first !== 1'b0) $display("FAIL s3_no_lock_after_slip: locked=%b expected 0", l_first);
    else n_pass++;
    send_sym(KB);
    n_checks++;
    if (l_last !== 1'b0) $display("FAIL s3_still_check: locked=%b expected 0", l_last);
    else n_pass++;
    send_sym(KA);
    n_checks++;
    if (l_first !== 1'b1) $display("FAIL s3_lock: locked=%b expected 1", l_first);
    else n_pass++;
    n_checks++;
    if (vsum !== 0) $display("FAIL s3_valid_before_lock: valids=%0d expected 0", vsum);
    else n_pass++;
    send_sym(KB);
    n_checks++;
    if (v_first !== 1'b1 || d_first !== KA)
      $display("FAIL s3_first_out: valid=%b data=%h expected 1 %h", v_first, d_first, KA);
    else n_pass++;
  endtask

  task automatic test_enable_low;
    enable = 1'b0;
    vsum = 0;
    tick(1'b0);
    n_checks++;
    if (locked !== 1'b0) $display("FAIL s4_unlock: locked=%b expected 0", locked);
    else n_pass++;
    repeat (4) tick(1'b0);
    n_checks++;
    if (vsum !== 0) $display("FAIL s4_valid_while_off: valids=%0d expected 0", vsum);
    else n_pass++;
    n_checks++;
    if (loss_cnt !== 8'd1) $display("FAIL s4_loss_kept: got %0d expected 1", loss_cnt);
    else n_pass++;
    enable = 1'b1;
    relock_fresh("s4");
  endtask

  task automatic test_reset_mid_symbol;
    logic [9:0] s;
    s = KA;
    for (int i = 0; i < 4; i++) tick(s[i]);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (locked !== 1'b0 || data_valid !== 1'b0 || data_k !== 1'b0)
      $display("FAIL s5_async_flags: locked=%b valid=%b k=%b expected 000", locked, data_valid, data_k);
    else n_pass++;
    n_checks++;
    if (data_out !== 10'd0 || loss_cnt !== 8'd0)
      $display("FAIL s5_async_values: data=%h loss=%0d expected 000 0", data_out, loss_cnt);
    else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 4; i < 10; i++) tick(s[i]);
    n_checks++;
    if (locked !== 1'b0) $display("FAIL s5_after_release: locked=%b expected 0", locked);
    else n_pass++;
    relock_fresh("s5");
  endtask

  // Each pass: extra bit, three misaligned commas (loss on the fourth
  // symbol's first bit), then four commas that relock at the new phase.
  task automatic test_loss_saturate;
    for (int e = 0; e < 256; e++) begin
      tick(1'b0);
      for (int j = 0; j < 7; j++) send_sym((j % 2 == 1) ? KB : KA);
      if (e == 0) begin
        n_checks++;
        if (loss_cnt !== 8'd1) $display("FAIL s6_first_event: got %0d expected 1", loss_cnt);
        else n_pass++;
      end
      if (e == 254) begin
        n_checks++;
        if (loss_cnt !== 8'hFF) $display("FAIL s6_reach_max: got %0d expected 255", loss_cnt);
        else n_pass++;
      end
    end
    n_checks++;
    if (loss_cnt !== 8'hFF) $display("FAIL s6_saturate: got %0d expected 255", loss_cnt);
    else n_pass++;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vsum = 0;
    test_reset;
    test_lock_stream;
    test_misaligned_loss;
    test_check_slip;
    test_enable_low;
    test_reset_mid_symbol;
    test_loss_saturate;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
